// File: rtl/ysyx_220053_csr_pkg.sv
// Shared machine-mode CSR definitions: trap controller state encoding,
// mcause values and CSR addresses used by the trap path and CSR file.
package ysyx_220053_csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ENTER = 3'd2,
    ST_REDIR = 3'd3,
    ST_RET   = 3'd4
  } trap_state_e;

  localparam logic [63:0] MCAUSE_ECALL_M = 64'h0000_0000_0000_000b;
  localparam logic [63:0] MCAUSE_MTI     = 64'h8000_0000_0000_0007;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

endpackage

// File: rtl/ysyx_220053_trap_ctrl.sv
// Machine-mode trap sequencer: accepts timer interrupt / ecall / mret in EX,
// waits for the LSU to drain (with a watchdog), then drives CSR update and PC redirect.
module ysyx_220053_trap_ctrl
  import ysyx_220053_csr_pkg::*;
#(
  parameter logic [63:0] CAUSE_ECALL = MCAUSE_ECALL_M,
  parameter logic [63:0] CAUSE_MTI   = MCAUSE_MTI,
  parameter logic [7:0]  DRAIN_MAX   = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic [63:0] pc_i,
  input  logic        mtip_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_mtie_i,
  input  logic        lsu_busy_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  output logic        trap_busy_o,
  output logic        csr_trap_o,
  output logic        csr_mret_o,
  output logic [63:0] csr_epc_o,
  output logic [63:0] csr_cause_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o,
  output logic        drain_timeout_o
);

  trap_state_e state_q, state_nxt;
  logic [63:0] epc_q, cause_q;
  logic [7:0]  drain_cnt_q;
  logic        irq, trap_req;

  assign irq      = mtip_i & mstatus_mie_i & mie_mtie_i;
  assign trap_req = irq | ecall_i;

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    state_nxt       = state_q;
    csr_trap_o      = 1'b0;
    csr_mret_o      = 1'b0;
    csr_epc_o       = '0;
    csr_cause_o     = '0;
    redirect_o      = 1'b0;
    redirect_pc_o   = '0;
    drain_timeout_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trap_req)    state_nxt = lsu_busy_i ? ST_DRAIN : ST_ENTER;
        else if (mret_i) state_nxt = ST_RET;
      end
      ST_DRAIN: begin
        if (!lsu_busy_i) begin
          state_nxt = ST_ENTER;
        end else if (drain_cnt_q == DRAIN_MAX) begin
          state_nxt       = ST_ENTER;
          drain_timeout_o = 1'b1;
        end
      end
      ST_ENTER: begin
        csr_trap_o  = 1'b1;
        csr_epc_o   = epc_q;
        csr_cause_o = cause_q;
        state_nxt   = ST_REDIR;
      end
      ST_REDIR: begin
        redirect_o    = 1'b1;
        // mtvec is used in direct mode only; the mode bits are masked off.
        redirect_pc_o = mtvec_i & ~64'h3;
        state_nxt     = ST_IDLE;
      end
      ST_RET: begin
        csr_mret_o    = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_i;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trap_busy_o <= 1'b0;
      epc_q       <= '0;
      cause_q     <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_nxt;
      trap_busy_o <= (state_nxt != ST_IDLE);
      if (state_q == ST_IDLE && trap_req) begin
        epc_q       <= pc_i;
        cause_q     <= irq ? CAUSE_MTI : CAUSE_ECALL;
        drain_cnt_q <= '0;
      end else if (state_q == ST_DRAIN) begin
        drain_cnt_q <= drain_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220053_trap_ctrl.sv
// Self-checking bench for ysyx_220053_trap_ctrl: directed scenarios then random
// traffic, all compared against a schedule-based reference model.
module tb_ysyx_220053_trap_ctrl;

  localparam logic [7:0]  DMAX      = 8'd4;
  localparam logic [63:0] EXP_ECALL = 64'hb;
  localparam logic [63:0] EXP_MTI   = 64'h8000_0000_0000_0007;
  localparam int K_ENTER = 0, K_REDIR = 1, K_RET = 2;

  logic        clk = 1'b0;
  logic        rst, ecall_i, mret_i, mtip_i, mstatus_mie_i, mie_mtie_i, lsu_busy_i;
  logic [63:0] pc_i, mtvec_i, mepc_i;
  logic        trap_busy_o, csr_trap_o, csr_mret_o, redirect_o, drain_timeout_o;
  logic [63:0] csr_epc_o, csr_cause_o, redirect_pc_o;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of scheduled output pulses plus a drain wait tracker.
  int          sched[$];
  bit          draining;
  int          waited;
  logic [63:0] m_epc, m_cause;

  ysyx_220053_trap_ctrl #(.DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .ecall_i(ecall_i), .mret_i(mret_i), .pc_i(pc_i),
    .mtip_i(mtip_i), .mstatus_mie_i(mstatus_mie_i), .mie_mtie_i(mie_mtie_i),
    .lsu_busy_i(lsu_busy_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .trap_busy_o(trap_busy_o), .csr_trap_o(csr_trap_o), .csr_mret_o(csr_mret_o),
    .csr_epc_o(csr_epc_o), .csr_cause_o(csr_cause_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .drain_timeout_o(drain_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ecall_i = 0; mret_i = 0; mtip_i = 0; mstatus_mie_i = 0; mie_mtie_i = 0;
    lsu_busy_i = 0; rst = 0;
  endtask

  task automatic model_reset();
    sched.delete();
    draining = 0;
    waited   = 0;
  endtask

  // Check current-cycle outputs on the falling edge, advance the model, then
  // return 1 time unit after the next rising edge so the caller can drive inputs.
  task automatic step();
    logic        e_busy, e_trap, e_mret, e_redir, e_to, irq;
    logic [63:0] e_epc, e_cause, e_rpc;
    @(negedge clk);
    e_busy = (sched.size() != 0) || draining;
    e_trap = 0; e_mret = 0; e_redir = 0; e_to = 0;
    e_epc = '0; e_cause = '0; e_rpc = '0;
    if (sched.size() != 0) begin
      case (sched[0])
        K_ENTER: begin e_trap = 1; e_epc = m_epc; e_cause = m_cause; end
        K_REDIR: begin e_redir = 1; e_rpc = {mtvec_i[63:2], 2'b00}; end
        default: begin e_mret = 1; e_redir = 1; e_rpc = mepc_i; end
      endcase
    end else if (draining) begin
      e_to = lsu_busy_i && (waited == int'(DMAX));
    end
    check("trap_busy", 64'(trap_busy_o), 64'(e_busy));
    check("csr_trap", 64'(csr_trap_o), 64'(e_trap));
    check("csr_mret", 64'(csr_mret_o), 64'(e_mret));
    check("csr_epc", csr_epc_o, e_epc);
    check("csr_cause", csr_cause_o, e_cause);
    check("redirect", 64'(redirect_o), 64'(e_redir));
    check("redirect_pc", redirect_pc_o, e_rpc);
    check("drain_timeout", 64'(drain_timeout_o), 64'(e_to));

    irq = mtip_i & mstatus_mie_i & mie_mtie_i;
    if (rst) begin
      model_reset();
    end else if (sched.size() != 0) begin
      void'(sched.pop_front());
    end else if (draining) begin
      if (!lsu_busy_i || waited == int'(DMAX)) begin
        draining = 0;
        sched.push_back(K_ENTER);
        sched.push_back(K_REDIR);
      end else begin
        waited++;
      end
    end else if (irq || ecall_i) begin
      m_epc   = pc_i;
      m_cause = irq ? EXP_MTI : EXP_ECALL;
      if (lsu_busy_i) begin
        draining = 1;
        waited   = 0;
      end else begin
        sched.push_back(K_ENTER);
        sched.push_back(K_REDIR);
      end
    end else if (mret_i) begin
      sched.push_back(K_RET);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(trap_busy_o), 64'd0);
    check({tag, "_trap"}, 64'(csr_trap_o), 64'd0);
    check({tag, "_mret"}, 64'(csr_mret_o), 64'd0);
    check({tag, "_redir"}, 64'(redirect_o), 64'd0);
    check({tag, "_rpc"}, redirect_pc_o, 64'd0);
    check({tag, "_epc"}, csr_epc_o, 64'd0);
  endtask

  initial begin
    clear_inputs();
    pc_i = 64'h8000_0000; mtvec_i = 64'h8000_0100; mepc_i = 64'h8000_0014;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check_all_zero("reset");

    // ecall, LSU idle: ENTER next cycle, redirect the cycle after.
    ecall_i = 1; pc_i = 64'h8000_0010; mtvec_i = 64'h8000_0101;
    step();
    ecall_i = 0;
    check("ecall_trap", 64'(csr_trap_o), 64'd1);
    check("ecall_epc", csr_epc_o, 64'h8000_0010);
    check("ecall_cause", csr_cause_o, 64'hb);
    step();
    check("ecall_redirect", 64'(redirect_o), 64'd1);
    check("ecall_redirect_pc", redirect_pc_o, 64'h8000_0100);
    step();

    // mret: one-cycle RET with simultaneous restore and redirect.
    mret_i = 1; mepc_i = 64'h8000_0014;
    step();
    mret_i = 0;
    check("mret_pulse", 64'(csr_mret_o), 64'd1);
    check("mret_redirect_pc", redirect_pc_o, 64'h8000_0014);
    step();
    check("mret_idle", 64'(trap_busy_o), 64'd0);

    // Timer interrupt wins over a same-cycle ecall.
    mtip_i = 1; mie_mtie_i = 1; mstatus_mie_i = 1; ecall_i = 1; pc_i = 64'h8000_0020;
    step();
    clear_inputs();
    check("irq_cause", csr_cause_o, 64'h8000_0000_0000_0007);
    check("irq_epc", csr_epc_o, 64'h8000_0020);
    repeat (3) step();

    // Drain: LSU busy for three cycles, normal exit without timeout.
    ecall_i = 1; lsu_busy_i = 1; pc_i = 64'h8000_0030;
    step();
    ecall_i = 0;
    step(); step();
    lsu_busy_i = 0;
    step();
    check("drain_enter", 64'(csr_trap_o), 64'd1);
    repeat (2) step();

    // Drain watchdog: LSU stuck busy forces entry after DRAIN_MAX.
    ecall_i = 1; lsu_busy_i = 1; pc_i = 64'h8000_0040;
    step();
    ecall_i = 0;
    repeat (int'(DMAX)) step();
    check("drain_timeout_pulse", 64'(drain_timeout_o), 64'd1);
    step();
    check("timeout_enter", 64'(csr_trap_o), 64'd1);
    lsu_busy_i = 0;
    repeat (2) step();

    // Reset during DRAIN aborts the sequence.
    ecall_i = 1; lsu_busy_i = 1;
    step();
    ecall_i = 0;
    step();
    rst = 1;
    step();
    rst = 0; lsu_busy_i = 0;
    check_all_zero("rst_drain");
    repeat (3) step();

    // Reset during ENTER aborts before redirect.
    ecall_i = 1;
    step();
    ecall_i = 0; rst = 1;
    step();
    rst = 0;
    check_all_zero("rst_enter");
    repeat (2) step();

    // Next ecall after abort completes normally.
    ecall_i = 1; pc_i = 64'h8000_0050;
    step();
    ecall_i = 0;
    check("post_rst_epc", csr_epc_o, 64'h8000_0050);
    repeat (2) step();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      ecall_i       = ($urandom_range(0, 7) == 0);
      mret_i        = ($urandom_range(0, 7) == 0);
      mtip_i        = ($urandom_range(0, 5) == 0);
      mstatus_mie_i = ($urandom_range(0, 3) != 0);
      mie_mtie_i    = ($urandom_range(0, 3) != 0);
      lsu_busy_i    = (i % 200 < 20) ? 1'b1 : ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      pc_i          = {$urandom, $urandom};
      mtvec_i       = {$urandom, $urandom};
      mepc_i        = {$urandom, $urandom};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_trap_ctrl.md
YSYX_220053_TRAP_CTRL -- requirements
Module: ysyx_220053_trap_ctrl

Interface
REQ-001 SHALL have parameter CAUSE_ECALL, default 64'hb, mcause value for environment call from M-mode.
REQ-002 SHALL have parameter CAUSE_MTI, default 64'h8000_0000_0000_0007, mcause value for machine timer interrupt.
REQ-003 SHALL have parameter DRAIN_MAX, default 8'd255, maximum DRAIN cycles before forced entry.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port ecall_i  in  1  ecall decoded in EX this cycle.
REQ-007 SHALL have port mret_i  in  1  mret decoded in EX this cycle.
REQ-008 SHALL have port pc_i  in  64  PC of the EX instruction.
REQ-009 SHALL have port mtip_i  in  1  timer interrupt pending level.
REQ-010 SHALL have port mstatus_mie_i  in  1  mstatus.MIE from CSR file.
REQ-011 SHALL have port mie_mtie_i  in  1  mie.MTIE from CSR file.
REQ-012 SHALL have port lsu_busy_i  in  1  outstanding load/store in flight.
REQ-013 SHALL have port mtvec_i  in  64  and mepc_i  in  64  current CSR values.
REQ-014 SHALL have port trap_busy_o  out  1  front-end stall, registered.
REQ-015 SHALL have port csr_trap_o  out  1  one-cycle pulse: CSR file writes mepc/mcause, clears MIE/MPIE.
REQ-016 SHALL have port csr_mret_o  out  1  one-cycle pulse: CSR file restores MIE/MPIE.
REQ-017 SHALL have ports csr_epc_o  out  64  and csr_cause_o  out  64  valid while csr_trap_o high.
REQ-018 SHALL have ports redirect_o  out  1  and redirect_pc_o  out  64  one-cycle PC redirect.
REQ-019 SHALL have port drain_timeout_o  out  1  one-cycle pulse on forced drain exit.

Function
REQ-020 SHALL implement FSM states IDLE, DRAIN, ENTER, REDIR, RET.
REQ-021 Interrupt request irq SHALL be mtip_i & mstatus_mie_i & mie_mtie_i.
REQ-022 In IDLE, priority SHALL be irq > ecall_i > mret_i; lower requests in the same cycle are dropped.
REQ-023 On acceptance of irq or ecall, epc_q SHALL latch pc_i and cause_q SHALL latch CAUSE_MTI or CAUSE_ECALL respectively.
REQ-024 Accepted trap with lsu_busy_i=0 SHALL go IDLE->ENTER; with lsu_busy_i=1 SHALL go IDLE->DRAIN and clear drain_cnt.
REQ-025 DRAIN SHALL increment drain_cnt each cycle; exit to ENTER when lsu_busy_i=0 or drain_cnt==DRAIN_MAX; the latter SHALL pulse drain_timeout_o.
REQ-026 ENTER SHALL last one cycle with csr_trap_o=1, csr_epc_o=epc_q, csr_cause_o=cause_q, then go REDIR.
REQ-027 REDIR SHALL last one cycle with redirect_o=1, redirect_pc_o={mtvec_i[63:2],2'b00}, then go IDLE.
REQ-028 Accepted mret SHALL go IDLE->RET; RET SHALL last one cycle with csr_mret_o=1, redirect_o=1, redirect_pc_o=mepc_i, then go IDLE.
REQ-029 trap_busy_o SHALL be 1 in every state except IDLE; requests outside IDLE SHALL be ignored.
REQ-030 Trap latency SHALL be 2 cycles acceptance-to-redirect with no drain; mret latency SHALL be 1 cycle.
REQ-031 csr_trap_o, csr_mret_o and redirect_o SHALL never be high in the same cycle except csr_mret_o with redirect_o in RET.
REQ-032 csr_epc_o/csr_cause_o SHALL hold 0 when csr_trap_o=0; redirect_pc_o SHALL hold 0 when redirect_o=0.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, zero epc_q, cause_q, drain_cnt, and drive all outputs 0 next cycle.
REQ-034 rst asserted mid-trap (any state) SHALL abort the sequence with no csr_trap_o, csr_mret_o or redirect_o pulse after reset.

Structure
REQ-035 State encoding, CAUSE_ECALL, CAUSE_MTI and CSR addresses (0x300, 0x304, 0x305, 0x341, 0x342, 0x344) SHALL live in shared package ysyx_220053_csr_pkg.
REQ-036 Block SHALL be a single module; drain watchdog counter SHALL be inline, no sub-module.

Verification
REQ-037 ecall_i=1, pc_i=0x8000_0010, lsu idle, mtvec_i=0x8000_0100 -> cycle+1 csr_trap_o, epc 0x8000_0010, cause 0xb; cycle+2 redirect to 0x8000_0100.
REQ-038 mret_i=1, mepc_i=0x8000_0014 -> cycle+1 csr_mret_o=1, redirect_o=1, redirect_pc_o=0x8000_0014; cycle+2 IDLE.
REQ-039 mtip_i, mie_mtie_i, mstatus_mie_i, ecall_i all 1, pc_i=0x8000_0020 -> cause 0x8000_0000_0000_0007, epc 0x8000_0020, ecall dropped.
REQ-040 ecall with lsu_busy_i high 3 cycles -> DRAIN 3 cycles, then ENTER, no drain_timeout_o; lsu_busy_i stuck high, DRAIN_MAX=4 -> drain_timeout_o pulse, ENTER follows.
REQ-041 rst pulsed during DRAIN and during ENTER -> all outputs 0 following cycle, no redirect, next ecall handled normally.
